// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decoded ID operands and pipeline controls going in,
// registered EX fields and the IF/ID hold request coming back out.
interface id_ex_if #(
  parameter int CTRL_W = 16
);
  logic              id_valid;
  logic [31:0]       id_pc4;
  logic [31:0]       id_rs_data;
  logic [31:0]       id_rt_data;
  logic [31:0]       id_imm;
  logic [31:0]       id_simm;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic              id_uses_rt;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush;
  logic              ex_stall;

  logic              ex_valid;
  logic [31:0]       ex_pc4;
  logic [31:0]       ex_rs_data;
  logic [31:0]       ex_rt_data;
  logic [31:0]       ex_imm;
  logic [31:0]       ex_br_target;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              id_hold;

  modport master (
    output id_valid, id_pc4, id_rs_data, id_rt_data, id_imm, id_simm,
           id_rs, id_rt, id_rd, id_uses_rt, id_ctrl, flush, ex_stall,
    input  ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_br_target,
           ex_rs, ex_rt, ex_rd, ex_ctrl, id_hold
  );

  modport slave (
    input  id_valid, id_pc4, id_rs_data, id_rt_data, id_imm, id_simm,
           id_rs, id_rt, id_rd, id_uses_rt, id_ctrl, flush, ex_stall,
    output ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_br_target,
           ex_rs, ex_rt, ex_rd, ex_ctrl, id_hold
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS pipeline. Registers operands,
// immediates and control into EX, computes the branch target, and detects
// load-use hazards, inserting LOAD_LAT bubbles while holding IF/ID.
module id_ex_stage #(
  parameter int CTRL_W      = 16,
  parameter int MEMREAD_BIT = 3,
  parameter int LOAD_LAT    = 1
) (
  input logic   clk,
  input logic   reset,
  id_ex_if.slave bus
);

  typedef enum logic {RUN, LU_STALL} state_t;

  localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       lu_hit;
  logic       bubble;

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    lu_hit = bus.ex_valid && bus.ex_ctrl[MEMREAD_BIT] && bus.id_valid &&
             (bus.ex_rt != 5'd0) &&
             ((bus.ex_rt == bus.id_rs) ||
              (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
    bubble = (state == LU_STALL) || lu_hit;
  end

  // Hold request: flush wins, then a downstream stall, then a pending bubble.
  always_comb begin
    if (!reset)
      bus.id_hold = 1'b0;
    else if (bus.flush)
      bus.id_hold = 1'b0;
    else if (bus.ex_stall)
      bus.id_hold = 1'b1;
    else
      bus.id_hold = bubble;
  end

  // EX register bank and load-use bubble FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= RUN;
      cnt              <= '0;
      bus.ex_valid     <= 1'b0;
      bus.ex_pc4       <= '0;
      bus.ex_rs_data   <= '0;
      bus.ex_rt_data   <= '0;
      bus.ex_imm       <= '0;
      bus.ex_br_target <= '0;
      bus.ex_rs        <= '0;
      bus.ex_rt        <= '0;
      bus.ex_rd        <= '0;
      bus.ex_ctrl      <= '0;
    end else if (bus.flush) begin
      state        <= RUN;
      cnt          <= '0;
      bus.ex_valid <= 1'b0;
      bus.ex_ctrl  <= '0;
    end else if (!bus.ex_stall) begin
      // Data fields load every advancing cycle; on a bubble they are ignored
      // because ex_valid and ex_ctrl are forced low.
      bus.ex_pc4       <= bus.id_pc4;
      bus.ex_rs_data   <= bus.id_rs_data;
      bus.ex_rt_data   <= bus.id_rt_data;
      bus.ex_imm       <= bus.id_imm;
      bus.ex_br_target <= bus.id_pc4 + bus.id_simm;
      bus.ex_rs        <= bus.id_rs;
      bus.ex_rt        <= bus.id_rt;
      bus.ex_rd        <= bus.id_rd;
      unique case (state)
        RUN: begin
          if (lu_hit) begin
            bus.ex_valid <= 1'b0;
            bus.ex_ctrl  <= '0;
            if (LOAD_LAT > 1) begin
              state <= LU_STALL;
              cnt   <= CNT_INIT;
            end
          end else begin
            bus.ex_valid <= bus.id_valid;
            bus.ex_ctrl  <= bus.id_valid ? bus.id_ctrl : '0;
          end
        end
        LU_STALL: begin
          bus.ex_valid <= 1'b0;
          bus.ex_ctrl  <= '0;
          cnt          <= cnt - 3'd1;
          if (cnt == 3'd1)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (LOAD_LAT=1 and LOAD_LAT=3), directed
// scenarios plus randomized traffic against a behavioural model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4, rsd, rtd, imm, simm;
    logic [4:0]  rs, rt, rd;
    logic        uses_rt;
    logic [15:0] ctrl;
    logic        flush, stall;
  } drv_t;

  typedef struct packed {
    logic        v;
    logic [31:0] pc4, rsd, rtd, imm, br;
    logic [4:0]  rs, rt, rd;
    logic [15:0] ctrl;
    logic        hold;
  } obs_t;

  typedef struct {
    logic        v;
    logic [31:0] pc4, rsd, rtd, imm, br;
    logic [4:0]  rs, rt, rd;
    logic [15:0] ctrl;
    int          bub;
  } mdl_t;

  logic clk = 1'b0;
  logic reset;
  drv_t drv [2];
  obs_t obs [2];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    id_ex_if #(.CTRL_W(16)) bus ();
    id_ex_stage #(.CTRL_W(16), .MEMREAD_BIT(3), .LOAD_LAT(g == 0 ? 1 : 3)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
    );
    assign bus.id_valid   = drv[g].valid;
    assign bus.id_pc4     = drv[g].pc4;
    assign bus.id_rs_data = drv[g].rsd;
    assign bus.id_rt_data = drv[g].rtd;
    assign bus.id_imm     = drv[g].imm;
    assign bus.id_simm    = drv[g].simm;
    assign bus.id_rs      = drv[g].rs;
    assign bus.id_rt      = drv[g].rt;
    assign bus.id_rd      = drv[g].rd;
    assign bus.id_uses_rt = drv[g].uses_rt;
    assign bus.id_ctrl    = drv[g].ctrl;
    assign bus.flush      = drv[g].flush;
    assign bus.ex_stall   = drv[g].stall;
    assign obs[g] = {bus.ex_valid, bus.ex_pc4, bus.ex_rs_data, bus.ex_rt_data,
                     bus.ex_imm, bus.ex_br_target, bus.ex_rs, bus.ex_rt,
                     bus.ex_rd, bus.ex_ctrl, bus.id_hold};
  end

  localparam logic [15:0] LW = 16'h0008;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int k, input logic v, input logic [31:0] pc4,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic ur,
                        input logic [15:0] ctrl);
    drv[k].valid   = v;
    drv[k].pc4     = pc4;
    drv[k].rsd     = $urandom;
    drv[k].rtd     = $urandom;
    drv[k].imm     = $urandom;
    drv[k].simm    = drv[k].imm << 2;
    drv[k].rs      = rs;
    drv[k].rt      = rt;
    drv[k].rd      = rd;
    drv[k].uses_rt = ur;
    drv[k].ctrl    = ctrl;
    drv[k].flush   = 1'b0;
    drv[k].stall   = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    drv[0] = '0;
    drv[1] = '0;
    tick();
    set_in(0, 1'b1, 32'h1234_5678, 5'd8, 5'd9, 5'd1, 1'b1, 16'hFFFF);
    set_in(1, 1'b1, 32'h1234_5678, 5'd8, 5'd9, 5'd1, 1'b1, 16'hFFFF);
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== '0)
        $display("FAIL reset_state k=%0d got=%h exp=0", k, obs[k]);
      else passed++;
    end
    drv[0] = '0;
    drv[1] = '0;
    reset  = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    set_in(0, 1'b1, 32'h0040_0004, 5'd1, 5'd2, 5'd3, 1'b0, 16'h0001);
    drv[0].imm  = 32'hFFFF_FFFC;
    drv[0].simm = 32'hFFFF_FFF0;
    #1;
    checks++;
    if (obs[0].hold !== 1'b0) $display("FAIL addi_hold got=%b exp=0", obs[0].hold);
    else passed++;
    tick();
    checks++;
    if ({obs[0].v, obs[0].br, obs[0].imm, obs[0].ctrl} !== {1'b1, 32'h003F_FFF4, 32'hFFFF_FFFC, 16'h0001})
      $display("FAIL addi_ex got v=%b br=%h imm=%h ctrl=%h exp v=1 br=003ffff4 imm=fffffffc ctrl=0001",
               obs[0].v, obs[0].br, obs[0].imm, obs[0].ctrl);
    else passed++;
  endtask

  task automatic test_load_use1();
    set_in(0, 1'b1, 32'h100, 5'd1, 5'd8, 5'd0, 1'b0, LW);
    tick();
    set_in(0, 1'b1, 32'h104, 5'd8, 5'd3, 5'd4, 1'b1, 16'h0002);
    #1;
    checks++;
    if (obs[0].hold !== 1'b1) $display("FAIL lu1_hold got=%b exp=1", obs[0].hold);
    else passed++;
    tick();
    checks++;
    if ({obs[0].v, obs[0].ctrl, obs[0].hold} !== {1'b0, 16'h0, 1'b0})
      $display("FAIL lu1_bubble got v=%b ctrl=%h hold=%b exp v=0 ctrl=0 hold=0", obs[0].v, obs[0].ctrl, obs[0].hold);
    else passed++;
    tick();
    checks++;
    if ({obs[0].v, obs[0].ctrl, obs[0].rs} !== {1'b1, 16'h0002, 5'd8})
      $display("FAIL lu1_enter got v=%b ctrl=%h rs=%0d exp v=1 ctrl=0002 rs=8", obs[0].v, obs[0].ctrl, obs[0].rs);
    else passed++;
    set_in(0, 1'b1, 32'h108, 5'd1, 5'd8, 5'd0, 1'b0, LW);
    tick();
    set_in(0, 1'b1, 32'h10C, 5'd1, 5'd8, 5'd5, 1'b0, 16'h0003);
    #1;
    checks++;
    if (obs[0].hold !== 1'b0) $display("FAIL lu1_nouse_hold got=%b exp=0", obs[0].hold);
    else passed++;
    tick();
    checks++;
    if ({obs[0].v, obs[0].ctrl} !== {1'b1, 16'h0003})
      $display("FAIL lu1_nouse_enter got v=%b ctrl=%h exp v=1 ctrl=0003", obs[0].v, obs[0].ctrl);
    else passed++;
  endtask

  task automatic test_lat3();
    set_in(1, 1'b1, 32'h200, 5'd1, 5'd9, 5'd0, 1'b0, LW);
    tick();
    set_in(1, 1'b1, 32'h204, 5'd2, 5'd9, 5'd6, 1'b1, 16'h0004);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs[1].hold !== 1'b1) $display("FAIL lat3_hold i=%0d got=%b exp=1", i, obs[1].hold);
      else passed++;
      tick();
      checks++;
      if ({obs[1].v, obs[1].ctrl} !== 17'h0)
        $display("FAIL lat3_bubble i=%0d got v=%b ctrl=%h exp v=0 ctrl=0", i, obs[1].v, obs[1].ctrl);
      else passed++;
    end
    checks++;
    if (obs[1].hold !== 1'b0) $display("FAIL lat3_release got=%b exp=0", obs[1].hold);
    else passed++;
    tick();
    checks++;
    if ({obs[1].v, obs[1].ctrl, obs[1].rt} !== {1'b1, 16'h0004, 5'd9})
      $display("FAIL lat3_enter got v=%b ctrl=%h rt=%0d exp v=1 ctrl=0004 rt=9", obs[1].v, obs[1].ctrl, obs[1].rt);
    else passed++;
  endtask

  task automatic test_zero();
    set_in(0, 1'b1, 32'h300, 5'd1, 5'd0, 5'd0, 1'b0, LW);
    tick();
    set_in(0, 1'b1, 32'h304, 5'd0, 5'd0, 5'd7, 1'b1, 16'h0005);
    #1;
    checks++;
    if (obs[0].hold !== 1'b0) $display("FAIL zero_hold got=%b exp=0", obs[0].hold);
    else passed++;
    tick();
    checks++;
    if ({obs[0].v, obs[0].ctrl} !== {1'b1, 16'h0005})
      $display("FAIL zero_enter got v=%b ctrl=%h exp v=1 ctrl=0005", obs[0].v, obs[0].ctrl);
    else passed++;
  endtask

  task automatic test_priority();
    set_in(1, 1'b1, 32'h1000, 5'd1, 5'd2, 5'd3, 1'b0, 16'h0010);
    tick();
    set_in(1, 1'b1, 32'h2000, 5'd4, 5'd5, 5'd6, 1'b0, 16'h0020);
    drv[1].stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (obs[1].hold !== 1'b1) $display("FAIL stall_hold i=%0d got=%b exp=1", i, obs[1].hold);
      else passed++;
      tick();
      checks++;
      if ({obs[1].v, obs[1].pc4, obs[1].ctrl} !== {1'b1, 32'h1000, 16'h0010})
        $display("FAIL stall_keep i=%0d got v=%b pc4=%h ctrl=%h exp v=1 pc4=00001000 ctrl=0010",
                 i, obs[1].v, obs[1].pc4, obs[1].ctrl);
      else passed++;
    end
    drv[1].flush = 1'b1;
    #1;
    checks++;
    if (obs[1].hold !== 1'b0) $display("FAIL flush_stall_hold got=%b exp=0", obs[1].hold);
    else passed++;
    tick();
    checks++;
    if ({obs[1].v, obs[1].ctrl} !== 17'h0)
      $display("FAIL flush_stall_ex got v=%b ctrl=%h exp v=0 ctrl=0", obs[1].v, obs[1].ctrl);
    else passed++;
    set_in(1, 1'b1, 32'h3000, 5'd1, 5'd9, 5'd0, 1'b0, LW);
    tick();
    set_in(1, 1'b1, 32'h3004, 5'd9, 5'd1, 5'd2, 1'b1, 16'h0040);
    tick();
    checks++;
    if (obs[1].hold !== 1'b1) $display("FAIL lus_hold got=%b exp=1", obs[1].hold);
    else passed++;
    drv[1].flush = 1'b1;
    #1;
    checks++;
    if (obs[1].hold !== 1'b0) $display("FAIL flush_lus_hold got=%b exp=0", obs[1].hold);
    else passed++;
    tick();
    drv[1].flush = 1'b0;
    #1;
    checks++;
    if ({obs[1].v, obs[1].hold} !== 2'b00)
      $display("FAIL flush_lus_run got v=%b hold=%b exp v=0 hold=0", obs[1].v, obs[1].hold);
    else passed++;
    tick();
    checks++;
    if ({obs[1].v, obs[1].ctrl} !== {1'b1, 16'h0040})
      $display("FAIL flush_lus_enter got v=%b ctrl=%h exp v=1 ctrl=0040", obs[1].v, obs[1].ctrl);
    else passed++;
  endtask

  task automatic test_async_reset();
    set_in(1, 1'b1, 32'h4000, 5'd1, 5'd9, 5'd0, 1'b0, LW);
    tick();
    set_in(1, 1'b1, 32'h5000, 5'd9, 5'd2, 5'd3, 1'b0, 16'h0080);
    drv[1].simm = 32'h0000_0010;
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs[1] !== '0) $display("FAIL async_reset got=%h exp=0", obs[1]);
    else passed++;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (obs[1].hold !== 1'b0) $display("FAIL async_post_hold got=%b exp=0", obs[1].hold);
    else passed++;
    tick();
    checks++;
    if ({obs[1].v, obs[1].ctrl, obs[1].pc4, obs[1].br} !== {1'b1, 16'h0080, 32'h5000, 32'h5010})
      $display("FAIL async_post_enter got v=%b ctrl=%h pc4=%h br=%h exp v=1 ctrl=0080 pc4=00005000 br=00005010",
               obs[1].v, obs[1].ctrl, obs[1].pc4, obs[1].br);
    else passed++;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      default: return 5'($urandom_range(1, 31));
    endcase
  endfunction

  // Load-use condition as stated for the pipeline, evaluated on the model's EX.
  function automatic bit hazard(input mdl_t e, input drv_t d);
    return e.v && e.ctrl[3] && d.valid && (e.rt != 5'd0) &&
           ((e.rt == d.rs) || (d.uses_rt && (e.rt == d.rt)));
  endfunction

  task automatic test_random();
    mdl_t m [2];
    logic eh [2];
    logic held [2];
    reset  = 1'b0;
    drv[0] = '0;
    drv[1] = '0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m[k] = '{v: 1'b0, pc4: '0, rsd: '0, rtd: '0, imm: '0, br: '0,
               rs: '0, rt: '0, rd: '0, ctrl: '0, bub: 0};
      held[k] = 1'b0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!held[k])
          set_in(k, $urandom_range(0, 7) != 0, $urandom, pick_reg(), pick_reg(),
                 5'($urandom), 1'($urandom), {$urandom_range(0, 1) == 1 ? 16'($urandom) | LW : 16'($urandom) & ~LW});
        drv[k].flush = ($urandom_range(0, 19) == 0);
        drv[k].stall = ($urandom_range(0, 9) == 0);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        eh[k] = drv[k].flush ? 1'b0 : drv[k].stall ? 1'b1 :
                ((m[k].bub > 0) || hazard(m[k], drv[k]));
        checks++;
        if (obs[k].hold !== eh[k])
          $display("FAIL rnd_hold k=%0d cyc=%0d got=%b exp=%b", k, c, obs[k].hold, eh[k]);
        else passed++;
        held[k] = eh[k];
        if (drv[k].flush) begin
          m[k].v = 1'b0; m[k].ctrl = '0; m[k].bub = 0;
        end else if (drv[k].stall) begin
          m[k].bub = m[k].bub;
        end else if (m[k].bub > 0) begin
          m[k].v = 1'b0; m[k].ctrl = '0; m[k].bub = m[k].bub - 1;
        end else if (hazard(m[k], drv[k])) begin
          m[k].v = 1'b0; m[k].ctrl = '0; m[k].bub = (k == 0) ? 0 : 2;
        end else begin
          m[k].v    = drv[k].valid;
          m[k].ctrl = drv[k].valid ? drv[k].ctrl : 16'h0;
          m[k].pc4  = drv[k].pc4;
          m[k].rsd  = drv[k].rsd;
          m[k].rtd  = drv[k].rtd;
          m[k].imm  = drv[k].imm;
          m[k].br   = drv[k].pc4 + drv[k].simm;
          m[k].rs   = drv[k].rs;
          m[k].rt   = drv[k].rt;
          m[k].rd   = drv[k].rd;
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({obs[k].v, obs[k].ctrl} !== {m[k].v, m[k].ctrl})
          $display("FAIL rnd_vc k=%0d cyc=%0d got v=%b ctrl=%h exp v=%b ctrl=%h",
                   k, c, obs[k].v, obs[k].ctrl, m[k].v, m[k].ctrl);
        else passed++;
        if (m[k].v) begin
          checks++;
          if ({obs[k].pc4, obs[k].rsd, obs[k].rtd, obs[k].imm, obs[k].br, obs[k].rs, obs[k].rt, obs[k].rd} !==
              {m[k].pc4, m[k].rsd, m[k].rtd, m[k].imm, m[k].br, m[k].rs, m[k].rt, m[k].rd})
            $display("FAIL rnd_data k=%0d cyc=%0d got pc4=%h br=%h imm=%h rt=%0d exp pc4=%h br=%h imm=%h rt=%0d",
                     k, c, obs[k].pc4, obs[k].br, obs[k].imm, obs[k].rt, m[k].pc4, m[k].br, m[k].imm, m[k].rt);
          else passed++;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, %0d/%0d", passed, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addi();
    test_load_use1();
    test_lat3();
    test_zero();
    test_priority();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
